instruction_loader: RTL

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader_if.sv | 28 ++
 rtl/instruction_loader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/instruction_loader_if.sv
// Byte-stream and memory-write signals of the instruction loader.
// The master side is the loader itself; the slave side is the byte source plus instruction memory.
interface instruction_loader_if;
    logic        byteValid;
    logic [7:0]  byteData;
    logic        byteReady;
    logic        writeEnable;
    logic [31:0] address;
    logic [31:0] dataIn;

    modport master (
        input  byteValid,
        input  byteData,
        output byteReady,
        output writeEnable,
        output address,
        output dataIn
    );

    modport slave (
        output byteValid,
        output byteData,
        input  byteReady,
        input  writeEnable,
        input  address,
        input  dataIn
    );
endinterface

// File: rtl/instruction_loader.sv
// Packs a byte stream into 32-bit instruction words and writes them to consecutive
// word addresses of an instruction memory, one session per accepted start request.
module instruction_loader #(
    parameter int DEPTH     = 1024,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        start,
    input  logic [10:0]                 wordCount,
    input  logic                        abort,
    instruction_loader_if.master        bus,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    localparam logic [11:0] DEPTH_W = 12'(DEPTH);

    state_t      state_q, state_d;
    logic [10:0] wordCount_q, wordCount_d;
    logic [10:0] wordIndex_q, wordIndex_d;
    logic [1:0]  byteIndex_q, byteIndex_d;
    logic [31:0] word_q, word_d;
    logic [31:0] address_q, address_d;
    logic [31:0] dataIn_q, dataIn_d;
    logic        error_q, error_d;

    logic        transfer;
    logic        writeNow;
    logic [4:0]  laneLo;

    assign transfer = (state_q == COLLECT) && bus.byteValid;
    assign writeNow = (state_q == WRITE) && !abort;
    assign laneLo   = MSB_FIRST ? {~byteIndex_q, 3'b000} : {byteIndex_q, 3'b000};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            wordCount_q <= '0;
            wordIndex_q <= '0;
            byteIndex_q <= '0;
            word_q      <= '0;
            address_q   <= '0;
            dataIn_q    <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wordCount_q <= wordCount_d;
            wordIndex_q <= wordIndex_d;
            byteIndex_q <= byteIndex_d;
            word_q      <= word_d;
            address_q   <= address_d;
            dataIn_q    <= dataIn_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wordCount_d = wordCount_q;
        wordIndex_d = wordIndex_q;
        byteIndex_d = byteIndex_q;
        word_d      = word_q;
        address_d   = address_q;
        dataIn_d    = dataIn_q;
        error_d     = error_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (wordCount == 11'd0) begin
                        error_d = 1'b0;
                        state_d = DONE;
                    end else if ({1'b0, wordCount} > DEPTH_W) begin
                        error_d = 1'b1;
                    end else begin
                        error_d     = 1'b0;
                        wordCount_d = wordCount;
                        wordIndex_d = '0;
                        byteIndex_d = '0;
                        word_d      = '0;
                        state_d     = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (transfer) begin
                    word_d[laneLo +: 8] = bus.byteData;
                    byteIndex_d         = byteIndex_q + 2'd1;
                    if (byteIndex_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                // The held address/data copies only change when the write really happens.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    address_d   = {21'b0, wordIndex_q};
                    dataIn_d    = word_q;
                    wordIndex_d = wordIndex_q + 11'd1;
                    byteIndex_d = '0;
                    state_d     = (wordIndex_q + 11'd1 == wordCount_q) ? DONE : COLLECT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.byteReady   = (state_q == COLLECT);
    assign bus.writeEnable = writeNow;
    assign bus.address     = writeNow ? {21'b0, wordIndex_q} : address_q;
    assign bus.dataIn      = writeNow ? word_q : dataIn_q;
    assign busy            = (state_q == COLLECT) || (state_q == WRITE);
    assign done            = (state_q == DONE);
    assign error           = error_q;

endmodule
